// File: rtl/iob_rr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin IOb arbiter.
package iob_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Pointer/select width; never below one bit so a 1-bit pointer still exists.
    function automatic int nb_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Round-robin priority encoder: first set bit of (req & ~mask) at or above ptr, with wrap.
module iob_rr_prio_enc #(
    parameter int N  = 2,
    parameter int NB = 1
) (
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  mask,
    input  logic [NB-1:0] ptr,
    output logic [NB-1:0] sel,
    output logic          found
);

    localparam int NW = NB + 1;

    logic [N-1:0]  w_cand;
    logic [NW-1:0] w_idx;

    assign w_cand = req & ~mask;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        w_idx = '0;
        // Walk from the farthest offset down so the candidate nearest ptr is written last.
        for (int i = N - 1; i >= 0; i--) begin
            w_idx = {1'b0, ptr} + NW'(i);
            if (w_idx >= NW'(N)) begin
                w_idx = w_idx - NW'(N);
            end
            if (w_cand[w_idx[NB-1:0]]) begin
                sel   = w_idx[NB-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Round-robin arbiter sharing one IOb slave among N_MASTERS masters.
// Handshake: a master holds m_valid and payload until its one-cycle m_ready pulse; s_valid stays high until s_ready completes it.
module iob_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic [N_MASTERS*DATA_W-1:0]     m_rdata,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_addr,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic                            s_ready,
    input  logic [DATA_W-1:0]               s_rdata,
    output logic [N_MASTERS-1:0]            grant,
    output logic                            busy
);

    import iob_rr_arbiter_pkg::*;

    localparam int NB = nb_width(N_MASTERS);
    localparam int SW = DATA_W / 8;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NB-1:0]         r_ptr;
    logic [NB-1:0]         r_gidx;
    logic [N_MASTERS-1:0]  r_grant;
    logic [ADDR_W-1:0]     r_s_addr;
    logic [DATA_W-1:0]     r_s_wdata;
    logic [SW-1:0]         r_s_wstrb;

    logic [NB-1:0]         w_ptr_inc;
    logic [NB-1:0]         w_search_ptr;
    logic [NB-1:0]         w_sel;
    logic [N_MASTERS-1:0]  w_mask;
    logic                  w_found;
    logic                  w_done;
    logic                  w_load;

    assign w_done       = (r_state == ST_BUSY) && s_ready;
    assign w_ptr_inc    = (int'(r_gidx) == N_MASTERS - 1) ? '0 : r_gidx + NB'(1);
    // On completion the finishing master's valid is still up, so it is masked out of the search.
    assign w_mask       = w_done ? r_grant : '0;
    assign w_search_ptr = (r_state == ST_BUSY) ? w_ptr_inc : r_ptr;
    assign w_load       = ((r_state == ST_IDLE) || w_done) && w_found;

    iob_rr_prio_enc #(
        .N  (N_MASTERS),
        .NB (NB)
    ) u_prio_enc (
        .req   (m_valid),
        .mask  (w_mask),
        .ptr   (w_search_ptr),
        .sel   (w_sel),
        .found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_found) w_state_nxt = ST_BUSY;
            ST_BUSY: if (s_ready && !w_found) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_s_addr  <= '0;
            r_s_wdata <= '0;
            r_s_wstrb <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_done) begin
                r_ptr <= w_ptr_inc;
            end
            if (w_load) begin
                r_gidx    <= w_sel;
                r_grant   <= N_MASTERS'(1) << w_sel;
                r_s_addr  <= m_addr[int'(w_sel)*ADDR_W +: ADDR_W];
                r_s_wdata <= m_wdata[int'(w_sel)*DATA_W +: DATA_W];
                r_s_wstrb <= m_wstrb[int'(w_sel)*SW +: SW];
            end else if (w_done) begin
                r_grant <= '0;
            end
        end
    end

    assign s_valid = (r_state == ST_BUSY);
    assign busy    = (r_state == ST_BUSY);
    assign grant   = r_grant;
    assign s_addr  = r_s_addr;
    assign s_wdata = r_s_wdata;
    assign s_wstrb = r_s_wstrb;
    assign m_ready = w_done ? r_grant : '0;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_resp
        assign m_rdata[k*DATA_W +: DATA_W] = r_grant[k] ? s_rdata : '0;
    end

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// Bench for iob_rr_arbiter with three masters: vector table, directed sequences and random traffic against a reference model.
module tb_iob_rr_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int NV = 20;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic [N-1:0]      m_valid = '0;
    logic [N*AW-1:0]   m_addr  = '0;
    logic [N*DW-1:0]   m_wdata = '0;
    logic [N*SW-1:0]   m_wstrb = '0;
    logic              s_ready = 1'b0;
    logic [DW-1:0]     s_rdata = '0;
    logic [N-1:0]      m_ready;
    logic [N*DW-1:0]   m_rdata;
    logic              s_valid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [N-1:0]      grant;
    logic              busy;

    iob_rr_arbiter #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ready (m_ready),
        .m_rdata (m_rdata),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_ready (s_ready),
        .s_rdata (s_rdata),
        .grant   (grant),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    logic [AW-1:0] exp_q[$];

    // Reference model state: what the shared port is doing right now.
    bit            md_busy  = 1'b0;
    int            md_g     = 0;
    int            md_ptr   = 0;
    logic [AW-1:0] md_addr  = '0;
    logic [DW-1:0] md_wdata = '0;
    logic [SW-1:0] md_wstrb = '0;

    logic [AW-1:0] pl_addr  [N];
    logic [DW-1:0] pl_wdata [N];
    logic [SW-1:0] pl_wstrb [N];
    bit   [N-1:0]  pending;

    typedef struct {
        logic         rst_n;
        logic [N-1:0] valid;
        logic         sready;
        logic [N-1:0] exp_grant;
        logic         exp_sv;
        logic [N-1:0] exp_mready;
    } vec_t;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            m_addr[k*AW +: AW]  = pl_addr[k];
            m_wdata[k*DW +: DW] = pl_wdata[k];
            m_wstrb[k*SW +: SW] = pl_wstrb[k];
        end
    endtask

    // Spec-level behaviour: on each edge either reset, hold, or pick the next requester after the pointer.
    task automatic model_step();
        int  excl;
        int  c;
        bit  found;
        if (!rst) begin
            md_busy  = 1'b0;
            md_g     = 0;
            md_ptr   = 0;
            md_addr  = '0;
            md_wdata = '0;
            md_wstrb = '0;
            exp_q.delete();
        end else if (!md_busy || s_ready) begin
            excl = -1;
            if (md_busy) begin
                md_ptr = (md_g + 1) % N;
                excl   = md_g;
            end
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (md_ptr + k) % N;
                if (!found && m_valid[c] && c != excl) begin
                    found    = 1'b1;
                    md_g     = c;
                    md_addr  = m_addr[c*AW +: AW];
                    md_wdata = m_wdata[c*DW +: DW];
                    md_wstrb = m_wstrb[c*SW +: SW];
                    exp_q.push_back(md_addr);
                end
            end
            md_busy = found;
        end
    endtask

    task automatic sample();
        logic [N-1:0]    eg;
        logic [N-1:0]    em;
        logic [N*DW-1:0] er;
        @(negedge clk);
        eg = md_busy ? (N'(1) << md_g) : '0;
        em = (md_busy && s_ready) ? eg : '0;
        er = '0;
        for (int k = 0; k < N; k++) begin
            if (md_busy && k == md_g) er[k*DW +: DW] = s_rdata;
        end
        chk("grant", grant, eg);
        chk("busy", busy, md_busy);
        chk("s_valid", s_valid, md_busy);
        chk("s_addr", s_addr, md_addr);
        chk("s_wdata", s_wdata, md_wdata);
        chk("s_wstrb", s_wstrb, md_wstrb);
        chk("m_ready", m_ready, em);
        chk("m_rdata", m_rdata, er);
        if (s_valid && s_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL sb_empty: got completion addr %0h expected no transaction", s_addr);
            end else begin
                chk("sb_addr", s_addr, exp_q.pop_front());
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[2]  = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[3]  = '{1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[4]  = '{1'b1, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001};
        vecs[5]  = '{1'b1, 3'b010, 1'b0, 3'b010, 1'b1, 3'b000};
        vecs[6]  = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
        vecs[7]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 3'b110, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[9]  = '{1'b1, 3'b110, 1'b1, 3'b100, 1'b1, 3'b100};
        vecs[10] = '{1'b1, 3'b110, 1'b1, 3'b010, 1'b1, 3'b010};
        vecs[11] = '{1'b1, 3'b110, 1'b1, 3'b100, 1'b1, 3'b100};
        vecs[12] = '{1'b1, 3'b110, 1'b0, 3'b010, 1'b1, 3'b000};
        vecs[13] = '{1'b0, 3'b110, 1'b0, 3'b010, 1'b1, 3'b000};
        vecs[14] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[15] = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[16] = '{1'b1, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
        vecs[17] = '{1'b1, 3'b001, 1'b1, 3'b000, 1'b0, 3'b000};
        vecs[18] = '{1'b1, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
        vecs[19] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};

        for (int k = 0; k < N; k++) begin
            pl_addr[k]  = 32'h1000 + AW'(16 * k);
            pl_wdata[k] = 32'hA000_0000 + DW'(k);
            pl_wstrb[k] = (k == 1) ? 4'h0 : 4'hF;
        end
        pending = '0;
        pack();

        // Table: reset hold, back-to-back grants, 1/2 alternation, reset mid-BUSY, same-master exclusion.
        for (int i = 0; i < NV; i++) begin
            rst     = vecs[i].rst_n;
            m_valid = vecs[i].valid;
            s_ready = vecs[i].sready;
            s_rdata = $urandom;
            sample();
            chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
            chk($sformatf("vec%0d_s_valid", i), s_valid, vecs[i].exp_sv);
            chk($sformatf("vec%0d_m_ready", i), m_ready, vecs[i].exp_mready);
            advance();
        end

        // Single read from master 1 with a three-cycle slave wait.
        pl_addr[1]  = 32'h40;
        pl_wstrb[1] = 4'h0;
        pack();
        rst = 1'b0; m_valid = '0; s_ready = 1'b0;
        sample(); advance();
        rst = 1'b1; m_valid = 3'b010;
        sample();
        chk("rd_sv_before", s_valid, 1'b0);
        advance();
        for (int w = 0; w < 3; w++) begin
            s_ready = 1'b0;
            sample();
            chk("rd_sv", s_valid, 1'b1);
            chk("rd_addr", s_addr, 32'h40);
            chk("rd_wait_ready", m_ready, 3'b000);
            advance();
        end
        s_ready = 1'b1; s_rdata = 32'hDEAD_BEEF;
        sample();
        chk("rd_ready", m_ready, 3'b010);
        chk("rd_rdata1", m_rdata[DW +: DW], 32'hDEAD_BEEF);
        chk("rd_rdata0", m_rdata[0 +: DW], 32'h0);
        advance();
        m_valid = '0; s_ready = 1'b0;
        sample();
        chk("rd_idle_sv", s_valid, 1'b0);
        chk("rd_idle_grant", grant, 3'b000);
        advance();
        // Pointer now sits at 2: master 2 wins over master 0, then wraps to 0.
        m_valid = 3'b101;
        sample(); advance();
        s_ready = 1'b1;
        sample();
        chk("wrap_first", grant, 3'b100);
        advance();
        m_valid = 3'b001;
        sample();
        chk("wrap_second", grant, 3'b001);
        advance();
        m_valid = '0; s_ready = 1'b0;
        sample(); advance();

        // All masters requesting with zero-wait slave: strict rotation, no gaps.
        rst = 1'b0;
        sample(); advance();
        rst = 1'b1; m_valid = 3'b111; s_ready = 1'b1;
        sample();
        chk("rr_start_sv", s_valid, 1'b0);
        advance();
        for (int i = 0; i < 7; i++) begin
            sample();
            chk($sformatf("rr_grant%0d", i), grant, N'(1) << (i % N));
            chk($sformatf("rr_sv%0d", i), s_valid, 1'b1);
            advance();
        end
        m_valid = '0;
        sample(); advance();
        s_ready = 1'b0;
        sample(); advance();

        // Random traffic with occasional resets and payload churn on waiting masters.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            for (int k = 0; k < N; k++) begin
                if (!pending[k] && $urandom_range(0, 3) == 0) begin
                    pending[k]  = 1'b1;
                    pl_addr[k]  = $urandom;
                    pl_wdata[k] = $urandom;
                    pl_wstrb[k] = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
                end else if (pending[k] && $urandom_range(0, 7) == 0) begin
                    pl_addr[k] = $urandom;
                end
                m_valid[k] = pending[k];
            end
            pack();
            s_ready = ($urandom_range(0, 2) != 0);
            s_rdata = $urandom;
            sample();
            for (int k = 0; k < N; k++) begin
                if (m_ready[k]) pending[k] = 1'b0;
            end
            advance();
        end

        chk("sb_drain", exp_q.size(), md_busy ? 1 : 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/iob_rr_arbiter.md
# iob_rr_arbiter

Round-robin arbiter sharing one IOb native slave port among N_MASTERS IOb native master ports. Requests are registered at grant, so the slave sees stable address and data for the whole transaction. The response is routed back only to the granted master. It sits between CPU/DMA-style masters and a single memory or peripheral slave, and replaces fixed-priority merging wherever starvation matters.

## Interface
- N_MASTERS, 2: number of masters, 2..16.
- DATA_W, 32: data width, a multiple of 8.
- ADDR_W, 32: address width.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- m_valid  input  N_MASTERS  per-master request valid.
- m_addr  input  N_MASTERS*ADDR_W  per-master address; master k uses bits [k*ADDR_W +: ADDR_W].
- m_wdata  input  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  input  N_MASTERS*DATA_W/8  per-master byte strobes; all zero means read.
- m_ready  output  N_MASTERS  per-master response pulse.
- m_rdata  output  N_MASTERS*DATA_W  per-master read data; zero for non-granted masters.
- s_valid, s_addr, s_wdata, s_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  slave request.
- s_ready, s_rdata  input  1/DATA_W  slave response.
- grant  output  N_MASTERS  one-hot grant; all zero when idle.
- busy  output  1  high in BUSY.

## Operation
- The FSM has two states, IDLE and BUSY.
- IDLE
  - If any m_valid bit is set, pick the first set bit searching upward from ptr with wrap-around.
  - Register that master's addr, wdata and wstrb into the s_* registers, set grant one-hot, and go to BUSY.
  - If no m_valid bit is set, stay in IDLE.
- BUSY
  - s_valid=1 and the s_* payload is held constant.
  - m_ready[g] equals s_ready, and m_rdata for master g equals s_rdata. All other masters see 0.
- Completion is the cycle in BUSY with s_ready=1.
  - ptr <= (g+1) mod N_MASTERS.
  - Re-arbitrate in the same cycle over m_valid with bit g masked, because that master's valid still belongs to the completing transaction.
  - If a candidate exists, load it and stay in BUSY (back-to-back grant).
  - Otherwise go to IDLE and clear grant.
- Masters hold m_valid and the payload until their m_ready pulse. Changes to a granted master's payload after grant are ignored. If a granted master drops m_valid, the transaction still completes.
- m_ready to any non-granted master is 0 in every cycle.
- s_ready while IDLE is ignored: no m_ready is generated and the state does not change.
- Reset (rst=0 at an edge)
  - state=IDLE, ptr=0, grant=0, busy=0.
  - s_valid=0, s_addr/s_wdata/s_wstrb=0.
  - m_ready=0, m_rdata=0.
  - Reset mid-transaction abandons the transaction; a later s_ready is ignored.
- Width rules
  - ptr width is Nb = max(1, clog2(N_MASTERS)).
  - The wrap is explicit: g+1 == N_MASTERS gives 0, which covers N_MASTERS that is not a power of two.

## Timing
- Request latency: m_valid sampled in IDLE at edge t gives s_valid=1 in the cycle after t.
- Response latency: combinational, zero cycles from s_ready/s_rdata to m_ready/m_rdata.
- Slave may assert s_ready in the first BUSY cycle. The minimum transaction is 1 cycle in BUSY.
- Back-to-back: with a competing request pending, s_valid stays high across completion and the payload changes at the completion edge. There are no idle cycles.
- Fairness: a continuously requesting master is granted within N_MASTERS-1 other transactions.

## Structure
- Package iob_rr_arbiter_pkg holds:
  - FSM state encoding: IDLE=1'b0, BUSY=1'b1.
  - The Nb width function.
- Sub-module iob_rr_prio_enc: combinational round-robin priority encoder.
  - Inputs: req[N], mask[N], ptr[Nb].
  - Outputs: sel[Nb], found.
  - The arbiter uses one instance for both the IDLE and completion searches, with mask set to 0 in IDLE and to one-hot g on completion.
- Payload mux, FSM and ptr/grant registers live in the top module.

## Test plan
- Reset: hold rst=0 for 3 cycles with m_valid=2'b11 and s_ready=1 → all outputs 0, grant=0. After release, the first grant goes to master 0.
- Single read: N=2, master 1 sends addr=0x40 with wstrb=0; the slave answers s_ready after 3 BUSY cycles with rdata=0xDEADBEEF.
  - s_valid rises 1 cycle after m_valid, with s_addr=0x40.
  - m_ready[1] pulses once with m_rdata[1]=0xDEADBEEF; m_ready[0]=0.
  - The FSM returns to IDLE and ptr=0.
- Round-robin: N=4, all masters request continuously and the slave has 0-wait ready → grants 0,1,2,3,0,… back-to-back with s_valid never dropping.
- Same-master exclusion: N=2, only master 0 requests continuously with 0-wait ready → one grant, then IDLE for 1 cycle, then re-grant. It must never issue two grants on one valid.
- Non-power-of-two: N=3 with masters 1 and 2 requesting → order 1,2,1,2. ptr wraps from 2 to 0 and the search skips master 0.
- Stray and reset cases:
  - s_ready in IDLE produces no m_ready.
  - rst=0 mid-BUSY forces IDLE. An s_ready arriving after reset produces no m_ready, and the payload registers read 0.
